// File: rtl/traffic_light_monitor.sv
`default_nettype none
// ============================================================================
// Module   : traffic_light_monitor
// Purpose  : Passive checker on the lamp outputs of the traffic-light
//            controller. Registers the lamps, tracks the phase sequence
//            RED -> YEL_RG -> GRN -> YEL_GR -> RED, and reports one-hot,
//            sequence and dwell-time faults as pulses, sticky flags and a
//            saturating fault count.
// Build    : define TLM_DWELL_CHECK_EN to build the dwell counter and the
//            MIN/MAX dwell checks. Without it err_dwell is tied low and the
//            *_MIN/*_MAX/DW parameters have no effect.
// Ports    : clk, rst            - clock, synchronous active-high reset
//            red/yellow/green    - observed lamps
//            clr                 - clears err_sticky
//            phase[1:0]          - decoded phase (00 R, 01 R->G Y, 10 G, 11 G->R Y)
//            locked              - monitor synchronised to the sequence
//            err_onehot/seq/dwell- one-clock fault pulses
//            err_sticky[2:0]     - {dwell, seq, onehot} sticky flags
//            fault_cnt[7:0]      - cycles with any fault, saturating
//            cycle_cnt[7:0]      - completed legal full cycles, wrapping
// Revision : 1.0 - initial release
// ============================================================================
module traffic_light_monitor #(
    parameter int RED_MIN = 1,
    parameter int RED_MAX = 16,
    parameter int YEL_MIN = 1,
    parameter int YEL_MAX = 4,
    parameter int GRN_MIN = 1,
    parameter int GRN_MAX = 12,
    parameter int DW      = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       red,
    input  logic       yellow,
    input  logic       green,
    input  logic       clr,
    output logic [1:0] phase,
    output logic       locked,
    output logic       err_onehot,
    output logic       err_seq,
    output logic       err_dwell,
    output logic [2:0] err_sticky,
    output logic [7:0] fault_cnt,
    output logic [7:0] cycle_cnt
);

    typedef enum logic [2:0] {
        S_SYNC   = 3'd0,
        S_RED    = 3'd1,
        S_YEL_RG = 3'd2,
        S_GRN    = 3'd3,
        S_YEL_GR = 3'd4
    } state_t;

    // ------------------------------------------------------------------
    // Input stage
    // ------------------------------------------------------------------
    logic [2:0] r_lamp_q;
    logic [2:0] r_lamp_qq;
    logic       r_lamp_vld;   // low until r_lamp_q holds a real sample

    always_ff @(posedge clk) begin
        if (rst) begin
            r_lamp_q   <= 3'b000;
            r_lamp_qq  <= 3'b000;
            r_lamp_vld <= 1'b0;
        end else begin
            r_lamp_q   <= {red, yellow, green};
            r_lamp_qq  <= r_lamp_q;
            r_lamp_vld <= 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Phase FSM
    // ------------------------------------------------------------------
    state_t     r_state;
    state_t     w_state_nxt;
    state_t     w_adv_state;
    logic [2:0] w_exp_lamp;
    logic       w_onehot;
    logic       w_same;
    logic       w_enter;
    logic       w_adv;
    logic       w_stay;
    logic       w_err_onehot;
    logic       w_err_seq;
    logic       w_err_dwell;
    logic       w_cyc_inc;

    assign w_onehot = (r_lamp_q == 3'b100) || (r_lamp_q == 3'b010) ||
                      (r_lamp_q == 3'b001);
    // In a locked state r_lamp_qq is always the lamp of the current phase.
    assign w_same   = (r_lamp_q == r_lamp_qq);

    // Lamp that legally leaves each locked state, and where it leads.
    always_comb begin
        w_exp_lamp  = 3'b000;
        w_adv_state = S_SYNC;
        case (r_state)
            S_RED:    begin w_exp_lamp = 3'b010; w_adv_state = S_YEL_RG; end
            S_YEL_RG: begin w_exp_lamp = 3'b001; w_adv_state = S_GRN;    end
            S_GRN:    begin w_exp_lamp = 3'b010; w_adv_state = S_YEL_GR; end
            S_YEL_GR: begin w_exp_lamp = 3'b100; w_adv_state = S_RED;    end
            default:  begin w_exp_lamp = 3'b000; w_adv_state = S_SYNC;   end
        endcase
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_enter      = 1'b0;
        w_adv        = 1'b0;
        w_stay       = 1'b0;
        w_err_onehot = 1'b0;
        w_err_seq    = 1'b0;
        if (r_lamp_vld) begin
            if (!w_onehot) begin
                // Non-one-hot always drops lock; never counts as a sequence error.
                w_err_onehot = 1'b1;
                w_state_nxt  = S_SYNC;
            end else if (r_state == S_SYNC) begin
                if (r_lamp_q == 3'b100) begin
                    w_enter     = 1'b1;
                    w_state_nxt = S_RED;
                end
            end else if (w_same) begin
                w_stay = 1'b1;
            end else if (r_lamp_q == w_exp_lamp) begin
                w_adv       = 1'b1;
                w_state_nxt = w_adv_state;
            end else begin
                w_err_seq   = 1'b1;
                w_state_nxt = S_SYNC;
            end
        end
    end

    assign w_cyc_inc = w_adv && (r_state == S_YEL_GR);

    // ------------------------------------------------------------------
    // Dwell checking
    // ------------------------------------------------------------------
`ifdef TLM_DWELL_CHECK_EN
    localparam logic [DW-1:0] c_RED_MIN = DW'(RED_MIN);
    localparam logic [DW-1:0] c_RED_MAX = DW'(RED_MAX);
    localparam logic [DW-1:0] c_YEL_MIN = DW'(YEL_MIN);
    localparam logic [DW-1:0] c_YEL_MAX = DW'(YEL_MAX);
    localparam logic [DW-1:0] c_GRN_MIN = DW'(GRN_MIN);
    localparam logic [DW-1:0] c_GRN_MAX = DW'(GRN_MAX);
    localparam logic [DW-1:0] c_DW_ONE  = DW'(1);

    logic [DW-1:0] r_dwell;
    logic [DW-1:0] w_dwell_nxt;
    logic [DW-1:0] w_min;
    logic [DW-1:0] w_max;

    always_comb begin
        w_min = '0;
        w_max = '1;
        case (r_state)
            S_RED:              begin w_min = c_RED_MIN; w_max = c_RED_MAX; end
            S_YEL_RG, S_YEL_GR: begin w_min = c_YEL_MIN; w_max = c_YEL_MAX; end
            S_GRN:              begin w_min = c_GRN_MIN; w_max = c_GRN_MAX; end
            default:            begin w_min = '0;        w_max = '1;        end
        endcase
    end

    always_comb begin
        w_dwell_nxt = '0;
        w_err_dwell = 1'b0;
        if (w_enter || w_adv) begin
            w_dwell_nxt = c_DW_ONE;
            if (w_adv && (r_dwell < w_min)) begin
                w_err_dwell = 1'b1;
            end
        end else if (w_stay) begin
            w_dwell_nxt = (r_dwell != '1) ? (r_dwell + c_DW_ONE) : r_dwell;
            // Fires only on the step to MAX+1, so once per over-long phase.
            if ((r_dwell == w_max) && (r_dwell != '1)) begin
                w_err_dwell = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_dwell <= '0;
        end else begin
            r_dwell <= w_dwell_nxt;
        end
    end
`else
    logic w_unused_cfg;

    assign w_err_dwell  = 1'b0;
    assign w_unused_cfg = ^{w_enter, w_stay,
                            ((RED_MIN + RED_MAX + YEL_MIN + YEL_MAX +
                              GRN_MIN + GRN_MAX + DW) != 0)};
`endif

    // ------------------------------------------------------------------
    // State, pulses, flags and counters
    // ------------------------------------------------------------------
    logic       r_err_onehot;
    logic       r_err_seq;
    logic       r_err_dwell;
    logic [2:0] r_sticky;
    logic [7:0] r_fault_cnt;
    logic [7:0] r_cycle_cnt;
    logic [2:0] w_pulses;

    assign w_pulses = {r_err_dwell, r_err_seq, r_err_onehot};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_SYNC;
            r_err_onehot <= 1'b0;
            r_err_seq    <= 1'b0;
            r_err_dwell  <= 1'b0;
            r_sticky     <= 3'b000;
            r_fault_cnt  <= 8'd0;
            r_cycle_cnt  <= 8'd0;
        end else begin
            r_state      <= w_state_nxt;
            r_err_onehot <= w_err_onehot;
            r_err_seq    <= w_err_seq;
            r_err_dwell  <= w_err_dwell;
            // A pulse arriving together with clr keeps its bit set.
            r_sticky     <= (r_sticky & ~{3{clr}}) | w_pulses;
            if ((w_pulses != 3'b000) && (r_fault_cnt != 8'hFF)) begin
                r_fault_cnt <= r_fault_cnt + 8'd1;
            end
            if (w_cyc_inc) begin
                r_cycle_cnt <= r_cycle_cnt + 8'd1;
            end
        end
    end

    always_comb begin
        phase = 2'b00;
        case (r_state)
            S_RED:    phase = 2'b00;
            S_YEL_RG: phase = 2'b01;
            S_GRN:    phase = 2'b10;
            S_YEL_GR: phase = 2'b11;
            default:  phase = 2'b00;
        endcase
    end

    assign locked     = (r_state != S_SYNC);
    assign err_onehot = r_err_onehot;
    assign err_seq    = r_err_seq;
    assign err_dwell  = r_err_dwell;
    assign err_sticky = r_sticky;
    assign fault_cnt  = r_fault_cnt;
    assign cycle_cnt  = r_cycle_cnt;

endmodule
`default_nettype wire

// File: tb/tb_traffic_light_monitor.sv
`default_nettype none
// ============================================================================
// Module   : tb_traffic_light_monitor
// Purpose  : Self-checking bench for traffic_light_monitor. A table of lamp
//            segments with hand-computed expected outputs, followed by
//            hand-written sequences for clear/reset priority, fault counter
//            saturation and cycle counter wrap. The DUT is built with
//            YEL_MIN=2 so a one-clock yellow violates the minimum dwell.
//            Dwell expectations follow TLM_DWELL_CHECK_EN.
// Revision : 1.0 - initial release
// ============================================================================
module tb_traffic_light_monitor;

`ifdef TLM_DWELL_CHECK_EN
    localparam int D = 1;
`else
    localparam int D = 0;
`endif

    localparam logic [2:0] c_R  = 3'b100;
    localparam logic [2:0] c_Y  = 3'b010;
    localparam logic [2:0] c_G  = 3'b001;
    localparam logic [2:0] c_RY = 3'b110;
    localparam logic [2:0] c_ST = 3'(4 * D + 3);

    logic       clk = 1'b0;
    logic       rst;
    logic       red;
    logic       yellow;
    logic       green;
    logic       clr;
    logic [1:0] phase;
    logic       locked;
    logic       err_onehot;
    logic       err_seq;
    logic       err_dwell;
    logic [2:0] err_sticky;
    logic [7:0] fault_cnt;
    logic [7:0] cycle_cnt;

    int n_checks = 0;
    int n_errors = 0;
    int n_oh = 0;
    int n_sq = 0;
    int n_dw = 0;

    traffic_light_monitor #(.YEL_MIN(2)) dut (
        .clk        (clk),
        .rst        (rst),
        .red        (red),
        .yellow     (yellow),
        .green      (green),
        .clr        (clr),
        .phase      (phase),
        .locked     (locked),
        .err_onehot (err_onehot),
        .err_seq    (err_seq),
        .err_dwell  (err_dwell),
        .err_sticky (err_sticky),
        .fault_cnt  (fault_cnt),
        .cycle_cnt  (cycle_cnt)
    );

    always #5 clk = ~clk;

    // Count clocks each pulse is high (a stretched pulse counts twice).
    always @(negedge clk) begin
        if (!rst) begin
            if (err_onehot) n_oh++;
            if (err_seq)    n_sq++;
            if (err_dwell)  n_dw++;
        end
    end

    typedef struct {
        logic [2:0] lamp;
        int         n;
        logic [1:0] ph;
        logic       lk;
        int         oh;
        int         sq;
        int         dw;
        int         fc;
        int         cc;
        logic [2:0] st;
    } vec_t;

    vec_t tbl[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Called at posedge+1; holds the lamp for n clocks, returns at posedge+1.
    task automatic drive(input logic [2:0] lamp, input int n);
        {red, yellow, green} = lamp;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check_all_reset(input string tag);
        check({tag, " phase"},      32'(phase),      32'd0);
        check({tag, " locked"},     32'(locked),     32'd0);
        check({tag, " err_onehot"}, 32'(err_onehot), 32'd0);
        check({tag, " err_seq"},    32'(err_seq),    32'd0);
        check({tag, " err_dwell"},  32'(err_dwell),  32'd0);
        check({tag, " err_sticky"}, 32'(err_sticky), 32'd0);
        check({tag, " fault_cnt"},  32'(fault_cnt),  32'd0);
        check({tag, " cycle_cnt"},  32'(cycle_cnt),  32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        // lamp, n, phase, locked, oh, seq, dwell, fault, cycles, sticky
        tbl.push_back('{c_R,  8, 2'b00, 1'b1, 0, 0, 0,     0,         0, 3'b000});
        tbl.push_back('{c_Y,  3, 2'b01, 1'b1, 0, 0, 0,     0,         0, 3'b000});
        tbl.push_back('{c_G,  8, 2'b10, 1'b1, 0, 0, 0,     0,         0, 3'b000});
        tbl.push_back('{c_Y,  3, 2'b11, 1'b1, 0, 0, 0,     0,         0, 3'b000});
        tbl.push_back('{c_R, 10, 2'b00, 1'b1, 0, 0, 0,     0,         1, 3'b000});
        tbl.push_back('{c_Y,  3, 2'b01, 1'b1, 0, 0, 0,     0,         1, 3'b000});
        tbl.push_back('{c_G,  8, 2'b10, 1'b1, 0, 0, 0,     0,         1, 3'b000});
        tbl.push_back('{c_Y,  3, 2'b11, 1'b1, 0, 0, 0,     0,         1, 3'b000});
        tbl.push_back('{c_R, 10, 2'b00, 1'b1, 0, 0, 0,     0,         2, 3'b000});
        tbl.push_back('{c_Y,  3, 2'b01, 1'b1, 0, 0, 0,     0,         2, 3'b000});
        tbl.push_back('{c_G,  8, 2'b10, 1'b1, 0, 0, 0,     0,         2, 3'b000});
        tbl.push_back('{c_Y,  3, 2'b11, 1'b1, 0, 0, 0,     0,         2, 3'b000});
        tbl.push_back('{c_R, 10, 2'b00, 1'b1, 0, 0, 0,     0,         3, 3'b000});
        // red straight to green: sequence error, drop lock, relock on red
        tbl.push_back('{c_G,  5, 2'b00, 1'b0, 0, 1, 0,     1,         3, 3'b010});
        tbl.push_back('{c_R,  4, 2'b00, 1'b1, 0, 1, 0,     1,         3, 3'b010});
        // red+yellow for two clocks: two one-hot pulses, then relock
        tbl.push_back('{c_RY, 2, 2'b00, 1'b0, 0, 1, 0,     1,         3, 3'b010});
        tbl.push_back('{c_R,  5, 2'b00, 1'b1, 2, 1, 0,     3,         3, 3'b011});
        // red held 20 clocks in total: one over-long pulse
        tbl.push_back('{c_R, 15, 2'b00, 1'b1, 2, 1, D,     3 + D,     3, c_ST});
        // one-clock yellow: under-minimum pulse on entering green
        tbl.push_back('{c_Y,  1, 2'b00, 1'b1, 2, 1, D,     3 + D,     3, c_ST});
        tbl.push_back('{c_G,  5, 2'b10, 1'b1, 2, 1, 2 * D, 3 + 2 * D, 3, c_ST});

        // ---------------- reset state and first lock ----------------
        rst = 1'b1; clr = 1'b0;
        {red, yellow, green} = c_R;
        repeat (3) @(posedge clk);
        #1;
        check_all_reset("reset");
        rst = 1'b0;
        @(posedge clk); #1;
        check("first edge locked",     32'(locked),     32'd0);
        check("first edge err_onehot", 32'(err_onehot), 32'd0);
        @(posedge clk); #1;
        check("second edge locked",    32'(locked),     32'd1);

        // ---------------- table ----------------
        for (int i = 0; i < tbl.size(); i++) begin
            drive(tbl[i].lamp, tbl[i].n);
            check($sformatf("v%0d phase", i),      32'(phase),      32'(tbl[i].ph));
            check($sformatf("v%0d locked", i),     32'(locked),     32'(tbl[i].lk));
            check($sformatf("v%0d onehot_n", i),   32'(n_oh),       32'(tbl[i].oh));
            check($sformatf("v%0d seq_n", i),      32'(n_sq),       32'(tbl[i].sq));
            check($sformatf("v%0d dwell_n", i),    32'(n_dw),       32'(tbl[i].dw));
            check($sformatf("v%0d fault_cnt", i),  32'(fault_cnt),  32'(tbl[i].fc));
            check($sformatf("v%0d cycle_cnt", i),  32'(cycle_cnt),  32'(tbl[i].cc));
            check($sformatf("v%0d err_sticky", i), 32'(err_sticky), 32'(tbl[i].st));
        end

        // ---------------- clr against a simultaneous err_seq ----------------
        // Now in green; red is an illegal next lamp.
        drive(c_R, 2);
        check("clr seq pulse",      32'(err_seq),    32'd1);
        check("clr seq locked",     32'(locked),     32'd0);
        clr = 1'b1;
        @(posedge clk); #1;
        check("clr sticky kept",    32'(err_sticky), 32'b010);
        check("clr pulse width",    32'(err_seq),    32'd0);
        check("clr relock",         32'(locked),     32'd1);
        check("clr fault_cnt",      32'(fault_cnt),  32'(4 + 2 * D));
        @(posedge clk); #1;
        check("clr sticky cleared", 32'(err_sticky), 32'b000);
        clr = 1'b0;
        drive(c_Y, 3);
        drive(c_G, 4);
        check("pre-reset phase",    32'(phase),      32'b10);
        check("pre-reset cycle",    32'(cycle_cnt),  32'd3);

        // ---------------- reset mid-green, overriding clr ----------------
        rst = 1'b1; clr = 1'b1;
        @(posedge clk); #1;
        check_all_reset("mid reset");
        rst = 1'b0; clr = 1'b0;

        // ---------------- fault counter saturation ----------------
        for (int i = 0; i < 300; i++) begin
            drive(3'b000, 1);
            drive(c_R, 1);
        end
        drive(c_R, 4);
        check("sat fault_cnt",  32'(fault_cnt),  32'd255);
        check("sat err_sticky", 32'(err_sticky), 32'b001);
        check("sat locked",     32'(locked),     32'd1);

        // ---------------- cycle counter wrap ----------------
        rst = 1'b1;
        {red, yellow, green} = c_R;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        drive(c_R, 2);
        for (int i = 0; i < 257; i++) begin
            drive(c_Y, 2);
            drive(c_G, 1);
            drive(c_Y, 2);
            drive(c_R, 1);
        end
        drive(c_R, 3);
        check("wrap cycle_cnt",  32'(cycle_cnt),  32'd1);
        check("wrap fault_cnt",  32'(fault_cnt),  32'd0);
        check("wrap locked",     32'(locked),     32'd1);
        check("wrap phase",      32'(phase),      32'd0);
        check("wrap err_sticky", 32'(err_sticky), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
